// File: rtl/serial_add_ctrl_add2_slice.sv
// Combinational 2-bit ripple adder built from two full adders.
// Port names match the existing 2-bit adder block so either can be dropped in.
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic w_c1;

    assign s[0] = a[0] ^ b[0] ^ ci;
    assign w_c1 = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ w_c1;
    assign co   = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 2-bit slice consumes a digit per clock, LSB first.
// WIDTH must be even and >= 2; CNT_W is derived and must not be overridden.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH / 2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cr;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0]         w_s;
    logic               w_co;
    logic               w_last;
    logic [WIDTH+1:0]   w_sum_ext;

    add2_slice u_slice (
        .a  (r_sa[1:0]),
        .b  (r_sb[1:0]),
        .ci (r_cr),
        .s  (w_s),
        .co (w_co)
    );

    // New digit enters at the top; dropping the low two bits keeps WIDTH=2 legal.
    assign w_sum_ext = {w_s, r_sum};
    assign w_last    = (r_cnt == CNT_W'(WIDTH / 2 - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_cr    <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cr    <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sa  <= r_sa >> 2;
                    r_sb  <= r_sb >> 2;
                    r_cr  <= w_co;
                    r_sum <= w_sum_ext[WIDTH+1:2];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, corner sequences, random adds.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int HALF  = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the whole add as one integer expression.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic c);
        return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
    endfunction

    // One add with start pulsed for a single edge; operands scrambled while busy.
    task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic [WIDTH-1:0] es,
                          input logic ec, input string name);
        int cyc;
        int busy_gaps;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        cyc = 0;
        busy_gaps = 0;
        while (!done && cyc < 4 * HALF) begin
            if (!busy) busy_gaps++;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, HALF);
        check({name, " busy gaps"}, busy_gaps, 0);
        check({name, " busy at done"}, int'(busy), 0);
        check({name, " sum"}, int'(sum), int'(es));
        check({name, " cout"}, int'(cout), int'(ec));
        @(negedge clk);
        check({name, " done clears"}, int'(done), 0);
        check({name, " sum held"}, int'(sum), int'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset sum",  int'(sum),  0);
        check("reset cout", int'(cout), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                   vecs[i].exp_cout, $sformatf("vec%0d", i));
        end

        // Start pulse with new operand while busy must be ignored.
        begin
            int cyc;
            int pulses;
            int first_done;
            logic [WIDTH-1:0] s_at_done;
            logic             c_at_done;
            @(negedge clk);
            start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
            @(negedge clk);
            start = 1'b0;
            pulses = 0; first_done = -1; s_at_done = '0; c_at_done = 1'b0;
            for (cyc = 0; cyc < 12; cyc++) begin
                if (cyc == 1) begin start = 1'b1; a = 8'hAA; b = 8'hAA; end
                if (cyc == 2) start = 1'b0;
                if (done) begin
                    pulses++;
                    if (first_done < 0) begin
                        first_done = cyc; s_at_done = sum; c_at_done = cout;
                    end
                end
                @(negedge clk);
            end
            check("ignore pulses", pulses, 1);
            check("ignore latency", first_done, HALF);
            check("ignore sum", int'(s_at_done), 32'h30);
            check("ignore cout", int'(c_at_done), 0);
        end

        // Leave cout=1 so the async reset has something to clear.
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "pre-reset");

        // Asynchronous reset between edges mid-RUN.
        begin
            int pulses;
            @(negedge clk);
            start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("mid-run busy before rst", int'(busy), 1);
            #2 rst = 1'b1;
            #1;
            check("async rst busy", int'(busy), 0);
            check("async rst done", int'(done), 0);
            check("async rst sum",  int'(sum),  0);
            check("async rst cout", int'(cout), 0);
            @(negedge clk);
            rst = 1'b0;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) pulses++;
            end
            check("no activity after rst", pulses, 0);
        end
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post-reset");

        // start held high: second add latched in the DONE cycle.
        begin
            int d_cyc [2];
            logic [WIDTH-1:0] d_sum [2];
            logic             d_cout [2];
            int n;
            @(negedge clk);
            start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
            @(negedge clk);
            a = 8'h80; b = 8'h80;
            n = 0;
            d_cyc[0] = -1; d_cyc[1] = -1;
            d_sum[0] = '0; d_sum[1] = '0; d_cout[0] = 1'b0; d_cout[1] = 1'b0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                if (done && n < 2) begin
                    d_cyc[n] = cyc; d_sum[n] = sum; d_cout[n] = cout;
                    n++;
                    if (n == 2) start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("b2b done count", n, 2);
            check("b2b first latency", d_cyc[0], HALF);
            check("b2b spacing", d_cyc[1] - d_cyc[0], HALF + 1);
            check("b2b sum0", int'(d_sum[0]), 32'h10);
            check("b2b cout0", int'(d_cout[0]), 0);
            check("b2b sum1", int'(d_sum[1]), 32'h00);
            check("b2b cout1", int'(d_cout[1]), 1);
            check("b2b idle after", int'(busy | done), 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            logic [WIDTH:0]   r;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            r  = model_add(ra, rb, rc);
            do_add(ra, rb, rc, r[WIDTH-1:0], r[WIDTH], $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Multi-cycle N-bit adder built from a 2-bit full-adder slice, processing 2 bits per clock, LSB first.
- Sits directly upstream of the 2-bit ripple-carry adder slice:
  - feeds the slice its operand bits and carry-in each cycle;
  - registers the slice's carry-out back as the next carry-in;
  - collects the slice's sum bits into an N-bit result.
- Start/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2.
- CNT_W, $clog2(WIDTH/2)+1, width of the digit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cin  input  1  initial carry-in; sampled only on an accepted start.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry-out, held until the next accepted start.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high. All state registers clear immediately on rst=1, independent of clk.
- Reset values:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - operand shift registers=0, carry register=0, counter=0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at an edge latches a, b into shift registers sa, sb and cin into the carry register cr;
  - clears counter; goes to RUN.
  - start=0: stay.
- RUN, each edge:
  - slice inputs are sa[1:0], sb[1:0], cr;
  - sa, sb shift right by 2 (zero-fill);
  - cr <= slice carry-out;
  - sum shifts right by 2 with the slice sum placed in sum[WIDTH-1:WIDTH-2];
  - counter increments.
  - On the edge where counter reaches WIDTH/2-1 (the last digit): go to DONE and set cout <= slice carry-out in the same edge.
- DONE:
  - done=1 for exactly this one cycle;
  - next edge returns to IDLE unless start=1, in which case the new operands are latched and the block goes straight to RUN (back-to-back accepted).
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state and are glitch-free.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH/2, low again after edge k+WIDTH/2+1. Throughput is one add per WIDTH/2+1 cycles.
- start while busy=1 is ignored. Operands a, b and cin may change freely while busy without effect.
- sum is undefined-free: it holds the previous result until overwritten.
  - Partial shifts during RUN are visible on sum; consumers must qualify with done.
- Result arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-RUN:
  - abort; all outputs return to reset values asynchronously;
  - no done pulse;
  - first start after reset release is accepted normally.
- start held high continuously: each accepted add is followed by one DONE cycle, then a new add starts.

Decomposition:
- No shared package is needed; the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) are local parameters in the module.
- One sub-module is natural: add2_slice. It is a purely combinational 2-bit ripple adder built from two full adders:
  - inputs: a[1:0], b[1:0], ci;
  - outputs: s[1:0], co.
- The controller instantiates exactly one add2_slice. The slice may be swapped for the existing 2-bit adder block without port changes.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulse at edge 0:
  - busy=1 during edges 1..4;
  - done=1 after edge 4 only;
  - sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1 (full carry ripple across all 4 digits).
- a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1; then a=0, b=0, cin=0 → sum=8'h00, cout=0.
- Start add 8'h10+8'h20. Pulse start with a=8'hAA at edge 2 while busy → ignored. Result 8'h30; done pulses exactly once.
- Assert rst asynchronously mid-RUN (between edges 2 and 3):
  - busy, done, sum, cout are 0 immediately;
  - no done pulse follows;
  - next start with 8'h01+8'h01 gives 8'h02, cout=0.
- Back-to-back adds:
  - start held high: 8'h0F+8'h01 then 8'h80+8'h80;
  - second add latched in the DONE cycle;
  - done pulses 5 cycles apart;
  - results 8'h10/cout=0, then 8'h00/cout=1.
